ysyx_25030093_ifu: RTL and testbench
====================================

// Module: ysyx_25030093_ifu
// PURPOSE
//  Instruction fetch unit, directly downstream of the PC register.
//  - Accepts a fetch address from the PC stage and issues one AXI4-Lite-style read on the instruction bus.
//  - Returns the fetched word to decode over a valid/ready handshake.
//  - Flags misaligned PC, bus error response and bus timeout as fetch faults.
// PARAMETERS
//  TIMEOUT_CYCLES  255          cycles spent in AR+R before a fetch is declared timed out (1..65535)
//  NOP_INST        32'h00000013 word driven on inst for faulted fetches and out of reset
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  pc           in   32  fetch address from PC stage
//  pc_valid     in   1   pc is valid this cycle
//  pc_ready     out  1   IFU can accept a new pc
//  araddr       out  32  instruction bus read address
//  arvalid      out  1   read address valid
//  arready      in   1   bus accepts address
//  rdata        in   32  read data
//  rresp        in   2   read response; 2'b00 = OKAY, anything else = error
//  rvalid       in   1   read data valid
//  rready       out  1   IFU accepts read data
//  inst         out  32  fetched instruction to decode
//  inst_pc      out  32  address of inst
//  inst_valid   out  1   inst/inst_pc/fault valid
//  inst_ready   in   1   decode consumes inst
//  fault        out  1   fetch faulted; qualified by inst_valid
//  fault_cause  out  2   01 = misaligned, 10 = bus error, 11 = timeout, 00 = none
//  perf_fetch   out  32  retired-fetch counter (see CONFIGURATION)
//  perf_stall   out  32  bus-wait cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  States
//  - IDLE: pc_ready=1.
//    - pc_valid: latch pc into fetch_pc.
//    - If pc[1:0]!=0: go to HOLD, inst=NOP_INST, fault=1, cause=01. No bus access is made.
//    - Otherwise go to AR.
//  - AR: arvalid=1, araddr=fetch_pc; both are decoded from state, no extra cycle. arready → R.
//  - R: rready=1. rvalid → inst=rdata, inst_pc=fetch_pc, fault=(rresp!=0), cause=10 if error; go to HOLD.
//  - HOLD: inst_valid=1, outputs stable. inst_ready → IDLE.
//  Timeout
//  - 16-bit counter, cleared on entry to AR, increments each cycle in AR or R.
//  - When it reaches TIMEOUT_CYCLES: go to HOLD, inst=NOP_INST, fault=1, cause=11.
//  - Timeout has priority over a same-cycle arready/rvalid; the late beat is dropped.
//  Timing and handshake
//  - Minimum latency: pc handshake in cycle 0, inst_valid in cycle 3 (arready=1, rvalid one cycle later).
//  - pc_ready=0 in AR/R/HOLD; exactly one outstanding fetch.
//  - Ready is never a function of the other side's valid.
//  - rvalid seen in AR: ignored, no capture.
//  Reset
//  - Async assert, any state: state=IDLE, arvalid=rready=inst_valid=fault=0, cause=00, inst=NOP_INST, inst_pc=0, counters=0.
//  - Reset mid-fetch abandons the transaction; the bus slave is reset by the same rst.
// CONFIGURATION
//  IFU_PERF_EN defined:
//  - perf_fetch increments on inst_valid&inst_ready.
//  - perf_stall increments each cycle in AR or R.
//  - Both wrap 32'hFFFFFFFF→0.
//  IFU_PERF_EN undefined: perf_fetch/perf_stall tied to 0, no counter flops.
// STRUCTURE
//  - Package ysyx_25030093_pkg: ifu_state_t {IDLE,AR,R,HOLD}, FAULT_NONE/MISALIGN/BUSERR/TIMEOUT, RESP_OKAY.
//  - One FSM + datapath module; no sub-module (timeout and perf counters are inline).
// TESTING
//  1. pc=0x80000000, arready=1, rvalid next cycle with rdata=0x00000297, rresp=0
//     → inst_valid in cycle 3, inst=0x00000297, inst_pc=0x80000000, fault=0.
//  2. pc=0x80000002 → no arvalid; HOLD next cycle, inst=0x00000013, fault=1, cause=01.
//  3. rresp=2'b10 on rvalid → fault=1, cause=10, inst=rdata.
//  4. arready held 0 → at TIMEOUT_CYCLES=255: fault=1, cause=11, inst=0x00000013.
//     A later rvalid is ignored.
//  5. inst_ready=0 for 5 cycles in HOLD → inst/inst_pc stable, pc_ready=0.
//     On inst_ready=1 → IDLE next cycle.
//  6. rst asserted while in R → same-cycle arvalid=rready=inst_valid=0.
//     After release, a fresh fetch completes normally.
//     With IFU_PERF_EN: counters=0 after reset; after test 1, perf_fetch=1, perf_stall=2.

Source files
------------

// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types and encodings for the ysyx_25030093 instruction fetch unit.
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AR   = 2'b01,
    R    = 2'b10,
    HOLD = 2'b11
  } ifu_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUSERR   = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25030093_ifu_if.sv
// PC-stage, instruction-bus and decode-side signals of the IFU.
// The master modport is the IFU itself; slave is its environment.
interface ysyx_25030093_ifu_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fault;
  logic [1:0]  fault_cause;

  modport master (
    input  pc, pc_valid, arready, rdata, rresp, rvalid, inst_ready,
    output pc_ready, araddr, arvalid, rready, inst, inst_pc, inst_valid,
           fault, fault_cause
  );

  modport slave (
    output pc, pc_valid, arready, rdata, rresp, rvalid, inst_ready,
    input  pc_ready, araddr, arvalid, rready, inst, inst_pc, inst_valid,
           fault, fault_cause
  );
endinterface

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite-style read per pc.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25030093_ifu_if.master        bus,
  output logic [31:0]                perf_fetch,
  output logic [31:0]                perf_stall
);

  ifu_state_t  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;

  // Timeout fires on the TIMEOUT_CYCLES-th cycle spent in AR+R.
  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.pc_valid) begin
          fetch_pc_d = bus.pc;
          tmo_d      = '0;
          if (is_misaligned(bus.pc)) begin
            state_d   = HOLD;
            inst_d    = NOP_INST;
            inst_pc_d = bus.pc;
            fault_d   = 1'b1;
            cause_d   = FAULT_MISALIGN;
          end else begin
            state_d = AR;
          end
        end
      end
      AR, R: begin
        tmo_d = tmo_q + 16'd1;
        if (tmo_hit) begin
          state_d   = HOLD;
          inst_d    = NOP_INST;
          inst_pc_d = fetch_pc_q;
          fault_d   = 1'b1;
          cause_d   = FAULT_TIMEOUT;
        end else if (state_q == AR) begin
          if (bus.arready) state_d = R;
        end else if (bus.rvalid) begin
          state_d   = HOLD;
          inst_d    = bus.rdata;
          inst_pc_d = fetch_pc_q;
          fault_d   = (bus.rresp != RESP_OKAY);
          cause_d   = (bus.rresp != RESP_OKAY) ? FAULT_BUSERR : FAULT_NONE;
        end
      end
      HOLD: begin
        if (bus.inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      inst_q     <= NOP_INST;
      inst_pc_q  <= '0;
      fault_q    <= 1'b0;
      cause_q    <= FAULT_NONE;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.pc_ready    = (state_q == IDLE);
  assign bus.arvalid     = (state_q == AR);
  assign bus.araddr      = fetch_pc_q;
  assign bus.rready      = (state_q == R);
  assign bus.inst_valid  = (state_q == HOLD);
  assign bus.inst        = inst_q;
  assign bus.inst_pc     = inst_pc_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.inst_valid && bus.inst_ready) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (state_q == AR || state_q == R)    perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed self-checking bench for ysyx_25030093_ifu (default TIMEOUT_CYCLES=255).
module tb_ysyx_25030093_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  int          checks;
  int          failures;

  ysyx_25030093_ifu_if ifc ();

  ysyx_25030093_ifu #(
    .TIMEOUT_CYCLES(255),
    .NOP_INST      (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_pc(input logic [31:0] addr);
    ifc.pc       = addr;
    ifc.pc_valid = 1'b1;
    step();
    ifc.pc_valid = 1'b0;
  endtask

  task automatic retire();
    ifc.inst_ready = 1'b1;
    step();
    ifc.inst_ready = 1'b0;
  endtask

  int          n;
  logic [31:0] exp_fetch, exp_stall;

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    ifc.pc         = '0;
    ifc.pc_valid   = 1'b0;
    ifc.arready    = 1'b0;
    ifc.rdata      = '0;
    ifc.rresp      = 2'b00;
    ifc.rvalid     = 1'b0;
    ifc.inst_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_pc_ready",   32'(ifc.pc_ready),    32'd1);
    check("rst_arvalid",    32'(ifc.arvalid),     32'd0);
    check("rst_rready",     32'(ifc.rready),      32'd0);
    check("rst_inst_valid", 32'(ifc.inst_valid),  32'd0);
    check("rst_inst",       ifc.inst,             32'h0000_0013);
    check("rst_inst_pc",    ifc.inst_pc,          32'h0);
    check("rst_fault",      32'(ifc.fault),       32'd0);
    check("rst_cause",      32'(ifc.fault_cause), 32'd0);
    check("rst_perf_fetch", perf_fetch,           32'd0);
    check("rst_perf_stall", perf_stall,           32'd0);
    rst = 1'b0;
    step();

    // Test 1: minimum-latency fetch
    ifc.arready = 1'b1;
    issue_pc(32'h8000_0000);
    check("t1_arvalid",  32'(ifc.arvalid),  32'd1);
    check("t1_araddr",   ifc.araddr,        32'h8000_0000);
    check("t1_pc_ready", 32'(ifc.pc_ready), 32'd0);
    ifc.rvalid = 1'b1;
    ifc.rdata  = 32'h0000_0297;
    ifc.rresp  = 2'b00;
    step();
    check("t1_rready_c2", 32'(ifc.rready),     32'd1);
    check("t1_ivalid_c2", 32'(ifc.inst_valid), 32'd0);
    step();
    ifc.rvalid = 1'b0;
    check("t1_ivalid_c3", 32'(ifc.inst_valid),  32'd1);
    check("t1_inst",      ifc.inst,             32'h0000_0297);
    check("t1_inst_pc",   ifc.inst_pc,          32'h8000_0000);
    check("t1_fault",     32'(ifc.fault),       32'd0);
    check("t1_cause",     32'(ifc.fault_cause), 32'd0);
    retire();
    check("t1_idle", 32'(ifc.pc_ready), 32'd1);
`ifdef IFU_PERF_EN
    exp_fetch = 32'd1;
    exp_stall = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    check("t1_perf_fetch", perf_fetch, exp_fetch);
    check("t1_perf_stall", perf_stall, exp_stall);

    // Test 2: misaligned pc, no bus access
    issue_pc(32'h8000_0002);
    check("t2_arvalid",    32'(ifc.arvalid),     32'd0);
    check("t2_inst_valid", 32'(ifc.inst_valid),  32'd1);
    check("t2_inst",       ifc.inst,             32'h0000_0013);
    check("t2_inst_pc",    ifc.inst_pc,          32'h8000_0002);
    check("t2_fault",      32'(ifc.fault),       32'd1);
    check("t2_cause",      32'(ifc.fault_cause), 32'd1);
    retire();

    // Test 3: bus error response, then Test 5: decode backpressure
    issue_pc(32'h8000_0010);
    ifc.rvalid = 1'b1;
    ifc.rdata  = 32'hDEAD_BEEF;
    ifc.rresp  = 2'b10;
    step();
    step();
    ifc.rvalid = 1'b0;
    ifc.rresp  = 2'b00;
    check("t3_inst_valid", 32'(ifc.inst_valid),  32'd1);
    check("t3_inst",       ifc.inst,             32'hDEAD_BEEF);
    check("t3_inst_pc",    ifc.inst_pc,          32'h8000_0010);
    check("t3_fault",      32'(ifc.fault),       32'd1);
    check("t3_cause",      32'(ifc.fault_cause), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_hold_valid", 32'(ifc.inst_valid), 32'd1);
      check("t5_hold_inst",  ifc.inst,            32'hDEAD_BEEF);
      check("t5_hold_pc",    ifc.inst_pc,         32'h8000_0010);
      check("t5_pc_ready",   32'(ifc.pc_ready),   32'd0);
    end
    retire();
    check("t5_idle_ready", 32'(ifc.pc_ready),   32'd1);
    check("t5_idle_valid", 32'(ifc.inst_valid), 32'd0);

    // Test 4a: arready never comes; HOLD on cycle 256 after the pc handshake
    ifc.arready = 1'b0;
    issue_pc(32'h8000_0020);
    n = 1;
    while (!ifc.inst_valid && n < 400) begin
      step();
      n++;
    end
    check("t4_tmo_cycle", 32'(n),               32'd256);
    check("t4_fault",     32'(ifc.fault),       32'd1);
    check("t4_cause",     32'(ifc.fault_cause), 32'd3);
    check("t4_inst",      ifc.inst,             32'h0000_0013);
    check("t4_inst_pc",   ifc.inst_pc,          32'h8000_0020);
    ifc.rvalid = 1'b1;
    ifc.rdata  = 32'h1234_5678;
    step();
    ifc.rvalid = 1'b0;
    check("t4_late_rready", 32'(ifc.rready), 32'd0);
    check("t4_late_inst",   ifc.inst,        32'h0000_0013);
    retire();

    // Test 4b: arready on the timeout cycle loses to the timeout
    issue_pc(32'h8000_0030);
    repeat (254) step();
    check("t4b_still_ar", 32'(ifc.arvalid),    32'd1);
    check("t4b_no_valid", 32'(ifc.inst_valid), 32'd0);
    ifc.arready = 1'b1;
    step();
    ifc.arready = 1'b0;
    check("t4b_valid",  32'(ifc.inst_valid),  32'd1);
    check("t4b_rready", 32'(ifc.rready),      32'd0);
    check("t4b_cause",  32'(ifc.fault_cause), 32'd3);
    retire();

    // Test 6: reset while in R, then a fresh fetch with rvalid ignored in AR
    ifc.arready = 1'b1;
    issue_pc(32'h8000_0040);
    step();
    check("t6_in_r", 32'(ifc.rready), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_arvalid",    32'(ifc.arvalid),    32'd0);
    check("t6_rst_rready",     32'(ifc.rready),     32'd0);
    check("t6_rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
    check("t6_rst_pc_ready",   32'(ifc.pc_ready),   32'd1);
    check("t6_rst_perf_fetch", perf_fetch,          32'd0);
    check("t6_rst_perf_stall", perf_stall,          32'd0);
    step();
    rst = 1'b0;
    step();
    ifc.arready = 1'b0;
    issue_pc(32'h8000_0044);
    ifc.rvalid = 1'b1;
    ifc.rdata  = 32'hBAD0_BAD0;
    check("t6_ar_rready", 32'(ifc.rready), 32'd0);
    step();
    ifc.rvalid  = 1'b0;
    ifc.arready = 1'b1;
    check("t6_ar_again", 32'(ifc.arvalid), 32'd1);
    step();
    ifc.arready = 1'b0;
    ifc.rvalid  = 1'b1;
    ifc.rdata   = 32'h0010_0073;
    step();
    ifc.rvalid = 1'b0;
    check("t6_valid",   32'(ifc.inst_valid), 32'd1);
    check("t6_inst",    ifc.inst,            32'h0010_0073);
    check("t6_inst_pc", ifc.inst_pc,         32'h8000_0044);
    check("t6_fault",   32'(ifc.fault),      32'd0);
    retire();
`ifdef IFU_PERF_EN
    exp_fetch = 32'd1;
    exp_stall = 32'd3;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    check("t6_perf_fetch", perf_fetch, exp_fetch);
    check("t6_perf_stall", perf_stall, exp_stall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
